// File: rtl/push_stage.sv
// push_stage: selects the stack push value and registers it with a valid strobe.
// Shifts run iteratively, one bit per cycle, under a start/busy/valid handshake.
module push_stage #(
    parameter int WIDTH     = 16,
    parameter int NREGS     = 4,
    parameter int IMM_W     = 8,
    parameter int DEF_SHAMT = 7,
    localparam int SW = $clog2(WIDTH) + 1,
    localparam int AW = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       push_src,
    input  logic             shift_src,
    input  logic             shamt_src,
    input  logic [1:0]       shift_mode,
    input  logic [SW-1:0]    shamt_in,
    input  logic             reg_write,
    input  logic [AW-1:0]    reg_addr,
    input  logic [IMM_W-1:0] imm_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [WIDTH-1:0] alu_in,
    input  logic [WIDTH-1:0] mem_in,
    input  logic [WIDTH-1:0] se_in,
    output logic [WIDTH-1:0] push_val,
    output logic             valid,
    output logic             busy
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [SW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [1:0]       mode_q, mode_d;
    logic [WIDTH-1:0] pv_q, pv_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] regs_q [NREGS];

    logic [SW-1:0]    amt;
    logic [SW-1:0]    n_eff;
    logic [WIDTH-1:0] sh_op;
    logic [WIDTH-1:0] src_val;

    // One bit of shift in the requested mode.
    function automatic logic [WIDTH-1:0] step_f(
        input logic [1:0]       m,
        input logic [WIDTH-1:0] v
    );
        logic [WIDTH-1:0] r;
        unique case (m)
            2'b00: r = {v[WIDTH-2:0], 1'b0};
            2'b01: r = {1'b0, v[WIDTH-1:1]};
            2'b10: r = {v[WIDTH-1], v[WIDTH-1:1]};
            2'b11: r = {v[0], v[WIDTH-1:1]};
        endcase
        return r;
    endfunction

    // Effective shift count: clamp for shifts, modulo for rotate.
    always_comb begin
        amt   = shamt_src ? shamt_in : SW'(DEF_SHAMT);
        sh_op = shift_src ? se_in : a_in;
        if (shift_mode == 2'b11) begin
            n_eff = SW'(32'(amt) % WIDTH);
        end else if (amt > SW'(WIDTH)) begin
            n_eff = SW'(WIDTH);
        end else begin
            n_eff = amt;
        end
    end

    // Non-shift source select; regfile read sees pre-write contents.
    always_comb begin
        src_val = pv_q;
        unique case (push_src)
            3'd0: src_val = WIDTH'(imm_in);
            3'd1: src_val = a_in;
            3'd2: src_val = pv_q;
            3'd3: src_val = mem_in;
            3'd4: src_val = regs_q[reg_addr];
            3'd5: src_val = alu_in;
            3'd6: src_val = b_in;
            3'd7: src_val = pv_q;
        endcase
    end

    // Next-state and result logic for the IDLE/SHIFT controller.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        mode_d  = mode_q;
        pv_d    = pv_q;
        valid_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (push_src != 3'd2) begin
                        pv_d    = src_val;
                        valid_d = 1'b1;
                    end else if (n_eff == '0) begin
                        pv_d    = sh_op;
                        valid_d = 1'b1;
                    end else if (n_eff == SW'(1)) begin
                        pv_d    = step_f(shift_mode, sh_op);
                        valid_d = 1'b1;
                    end else begin
                        work_d  = step_f(shift_mode, sh_op);
                        cnt_d   = n_eff - SW'(1);
                        mode_d  = shift_mode;
                        state_d = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                work_d = step_f(mode_q, work_q);
                cnt_d  = cnt_q - SW'(1);
                if (cnt_q == SW'(1)) begin
                    pv_d    = step_f(mode_q, work_q);
                    valid_d = 1'b1;
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    // Controller and result registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
            mode_q  <= '0;
            pv_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            mode_q  <= mode_d;
            pv_q    <= pv_d;
            valid_q <= valid_d;
        end
    end

    // Local register file, written independently of the controller.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (reg_write) begin
            regs_q[reg_addr] <= a_in;
        end
    end

    assign push_val = pv_q;
    assign valid    = valid_q;
    assign busy     = (state_q == S_SHIFT);

endmodule

// File: tb/tb_push_stage.sv
// Scoreboard bench for push_stage: driver predicts results from a
// behavioural model; a monitor checks every valid strobe and busy level.
module tb_push_stage;

    localparam int W  = 16;
    localparam int SW = 5;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [2:0]    push_src = '0;
    logic          shift_src = 1'b0;
    logic          shamt_src = 1'b0;
    logic [1:0]    shift_mode = '0;
    logic [SW-1:0] shamt_in = '0;
    logic          reg_write = 1'b0;
    logic [AW-1:0] reg_addr = '0;
    logic [7:0]    imm_in = '0;
    logic [W-1:0]  a_in = '0;
    logic [W-1:0]  b_in = '0;
    logic [W-1:0]  alu_in = '0;
    logic [W-1:0]  mem_in = '0;
    logic [W-1:0]  se_in = '0;
    logic [W-1:0]  push_val;
    logic          valid;
    logic          busy;

    push_stage #(
        .WIDTH(16), .NREGS(4), .IMM_W(8), .DEF_SHAMT(7)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .push_src(push_src), .shift_src(shift_src),
        .shamt_src(shamt_src), .shift_mode(shift_mode),
        .shamt_in(shamt_in), .reg_write(reg_write),
        .reg_addr(reg_addr), .imm_in(imm_in),
        .a_in(a_in), .b_in(b_in), .alu_in(alu_in),
        .mem_in(mem_in), .se_in(se_in),
        .push_val(push_val), .valid(valid), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [W-1:0] v;
        int           at;
    } exp_t;

    exp_t         q[$];
    int           total = 0;
    int           bad = 0;
    logic [W-1:0] mregs [4] = '{default: '0};
    logic [W-1:0] mpv = '0;
    int           free_edge = 0;
    int           busy_lo = 0;
    int           busy_hi = 0;

    function automatic logic [W-1:0] shref(
        input logic [1:0] m, input logic [W-1:0] op, input int n
    );
        logic [31:0] d;
        case (m)
            2'd0: return (n >= W) ? '0 : W'(op << n);
            2'd1: return (n >= W) ? '0 : W'(op >> n);
            2'd2: return (n >= W) ? {W{op[W-1]}}
                                  : W'($signed(op) >>> n);
            default: begin
                d = {op, op} >> n;
                return d[W-1:0];
            end
        endcase
    endfunction

    task automatic chk(input string nm,
                       input logic [W-1:0] got,
                       input logic [W-1:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, got, want);
        end
    endtask

    // Predict the effect of the upcoming edge, then advance one cycle.
    task automatic tick();
        int s, amt, n, lat;
        logic [W-1:0] r, op;
        s = cyc + 1;
        if (start && s >= free_edge) begin
            lat = 1;
            case (push_src)
                3'd0: r = {8'h00, imm_in};
                3'd1: r = a_in;
                3'd3: r = mem_in;
                3'd4: r = mregs[reg_addr];
                3'd5: r = alu_in;
                3'd6: r = b_in;
                3'd7: r = mpv;
                default: begin
                    amt = shamt_src ? int'(shamt_in) : 7;
                    if (shift_mode == 2'd3) n = amt % W;
                    else n = (amt > W) ? W : amt;
                    op = shift_src ? se_in : a_in;
                    r = shref(shift_mode, op, n);
                    if (n >= 2) lat = n;
                end
            endcase
            q.push_back('{r, s + lat - 1});
            mpv = r;
            free_edge = s + lat;
            busy_lo = s;
            busy_hi = s + lat - 1;
        end
        if (reg_write) mregs[reg_addr] = a_in;
        @(negedge clk);
        start = 1'b0;
        reg_write = 1'b0;
    endtask

    task automatic wait_idle();
        while (cyc + 1 < free_edge) tick();
    endtask

    task automatic shift_req(input logic ssrc, input logic [W-1:0] op,
                             input logic [1:0] m, input logic asrc,
                             input int amt);
        push_src = 3'd2;
        shift_src = ssrc;
        if (ssrc) se_in = op;
        else a_in = op;
        shift_mode = m;
        shamt_src = asrc;
        shamt_in = SW'(amt);
        start = 1'b1;
        tick();
    endtask

    // Monitor: busy level every cycle, scoreboard pop on each valid.
    always @(negedge clk) begin
        exp_t e;
        logic eb;
        if (reset) begin
            eb = (cyc >= busy_lo) && (cyc < busy_hi);
            total++;
            if (busy !== eb) begin
                bad++;
                $display("FAIL busy cyc=%0d got=%b want=%b", cyc, busy, eb);
            end
            if (valid === 1'b1) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL extra_valid cyc=%0d got=%h want=none",
                             cyc, push_val);
                end else begin
                    e = q.pop_front();
                    if (e.at != cyc || push_val !== e.v) begin
                        bad++;
                        $display("FAIL result cyc=%0d got=%h want=%h@%0d",
                                 cyc, push_val, e.v, e.at);
                    end
                end
            end else if (q.size() > 0 && q[0].at <= cyc) begin
                total++;
                bad++;
                e = q.pop_front();
                $display("FAIL missing_valid cyc=%0d got=none want=%h",
                         cyc, e.v);
            end
        end
    end

    initial begin
        #1;
        chk("reset_pv", push_val, 16'h0);
        chk("reset_valid", {15'h0, valid}, 16'h0);
        chk("reset_busy", {15'h0, busy}, 16'h0);
        #6 reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            push_src = 3'd4;
            reg_addr = AW'(i);
            start = 1'b1;
            tick();
        end

        push_src = 3'd0;
        imm_in = 8'hA5;
        start = 1'b1;
        tick();
        push_src = 3'd7;
        start = 1'b1;
        tick();
        tick();
        tick();

        shift_req(1'b0, 16'h0001, 2'd0, 1'b1, 5);
        tick();
        start = 1'b1;
        tick();
        wait_idle();
        tick();

        shift_req(1'b1, 16'h8000, 2'd2, 1'b1, 20);
        wait_idle();
        shift_req(1'b0, 16'h1234, 2'd3, 1'b1, 20);
        wait_idle();
        shift_req(1'b0, 16'hFF00, 2'd1, 1'b0, 31);
        wait_idle();
        tick();

        reg_write = 1'b1;
        reg_addr = 2'd2;
        a_in = 16'hBEEF;
        push_src = 3'd4;
        start = 1'b1;
        tick();
        push_src = 3'd4;
        start = 1'b1;
        tick();
        tick();

        for (int i = 0; i < 400; i++) begin
            start = ($urandom_range(0, 9) < 6);
            push_src = 3'($urandom_range(0, 7));
            shift_src = 1'($urandom);
            shamt_src = 1'($urandom);
            shift_mode = 2'($urandom);
            shamt_in = SW'($urandom_range(0, 31));
            reg_write = ($urandom_range(0, 9) < 3);
            reg_addr = AW'($urandom);
            imm_in = 8'($urandom);
            a_in = 16'($urandom);
            b_in = 16'($urandom);
            alu_in = 16'($urandom);
            mem_in = 16'($urandom);
            se_in = 16'($urandom);
            tick();
        end
        wait_idle();
        reg_write = 1'b1;
        reg_addr = 2'd2;
        a_in = 16'h5A5A;
        tick();
        tick();

        shift_req(1'b0, 16'h0003, 2'd0, 1'b1, 10);
        tick();
        tick();
        #2 reset = 1'b0;
        #1;
        chk("midrst_busy", {15'h0, busy}, 16'h0);
        chk("midrst_pv", push_val, 16'h0);
        chk("midrst_valid", {15'h0, valid}, 16'h0);
        q.delete();
        mpv = '0;
        free_edge = 0;
        busy_lo = 0;
        busy_hi = 0;
        for (int i = 0; i < 4; i++) mregs[i] = '0;
        @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        repeat (15) tick();

        push_src = 3'd4;
        reg_addr = 2'd2;
        start = 1'b1;
        tick();
        repeat (5) tick();

        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
